// File: rtl/log_range_reduce_if.sv
// ---------------------------------------------------------------------------
// log_range_reduce_if
// Bundles the signals of the log range-reduction front-end.
//   in_valid / in_ready / in_a : operand handshake (unsigned Q16.16 operand)
//   cord_x / cord_y / cord_vld : normalised operand presented to the CORDIC
//   al_vld / al_exp / al_err   : exponent and zero flag aligned to CORDIC z
// master: operand source and result sink.  slave: log_range_reduce.
// ---------------------------------------------------------------------------
interface log_range_reduce_if;
  logic               in_valid;
  logic               in_ready;
  logic        [31:0] in_a;
  logic signed [31:0] cord_x;
  logic signed [31:0] cord_y;
  logic               cord_vld;
  logic               al_vld;
  logic signed [5:0]  al_exp;
  logic               al_err;

  modport master (
    output in_valid, in_a,
    input  in_ready, cord_x, cord_y, cord_vld, al_vld, al_exp, al_err
  );

  modport slave (
    input  in_valid, in_a,
    output in_ready, cord_x, cord_y, cord_vld, al_vld, al_exp, al_err
  );
endinterface

// File: rtl/log_range_reduce.sv
// ---------------------------------------------------------------------------
// log_range_reduce
// Normalises an unsigned Q16.16 operand a = m * 2^e with m in [0.5, 1) and
// presents x = m+1, y = m-1 (signed Q2.30) to a hyperbolic CORDIC, so that
// z = 2*atanh(y/x) = ln(m). The exponent e and a zero-operand flag are
// delayed by CORDIC_LAT cycles so they line up with the CORDIC result.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of log_range_reduce_if (handshake, CORDIC drive,
//           aligned exponent/error outputs)
// ---------------------------------------------------------------------------
module log_range_reduce #(
  parameter int CORDIC_LAT = 19
) (
  input  logic                clk,
  input  logic                rst_n,
  log_range_reduce_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, NORM, EMIT} state_t;

  state_t             state_q, state_d;
  logic        [31:0] s_q, s_d;
  logic        [5:0]  k_q, k_d;
  logic               zero_q, zero_d;
  logic               emit;

  logic signed [31:0] cord_x_q, cord_y_q;
  logic               cord_vld_q;
  logic signed [5:0]  exp_q;
  logic               err_q;

  logic               dl_vld_q [CORDIC_LAT];
  logic signed [5:0]  dl_exp_q [CORDIC_LAT];
  logic               dl_err_q [CORDIC_LAT];

  // e = 16 - k; k <= 31 keeps the result inside -15..+16.
  function automatic logic signed [5:0] exp_of(input logic [5:0] k);
    logic signed [6:0] t;
    t = 7'sd16 - $signed({1'b0, k});
    return t[5:0];
  endfunction

  assign bus.in_ready = (state_q == IDLE);

  // The transition into EMIT looks at the value s is about to take, so the
  // normalisation check costs no extra cycle: cord_vld lands S+1 cycles after
  // acceptance and the FSM is back in IDLE in that same cycle.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    zero_d  = zero_q;
    emit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          s_d    = bus.in_a;
          k_d    = 6'd0;
          zero_d = (bus.in_a == 32'd0);
          if (bus.in_a == 32'd0 || bus.in_a[31]) state_d = EMIT;
          else                                   state_d = NORM;
        end
      end
      NORM: begin
        if (s_q[31:24] == 8'd0) begin
          s_d = s_q << 8;
          k_d = k_q + 6'd8;
        end else if (!s_q[31]) begin
          s_d = s_q << 1;
          k_d = k_q + 6'd1;
        end
        if (s_d[31]) state_d = EMIT;
      end
      EMIT: begin
        emit    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      zero_q  <= zero_d;
    end
  end

  // CORDIC operand registers: x = {01, m}, y = {11, m} in Q2.30; they hold
  // between operands and cord_vld qualifies the single meaningful cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cord_x_q   <= '0;
      cord_y_q   <= '0;
      cord_vld_q <= 1'b0;
      exp_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      cord_vld_q <= emit;
      if (emit) begin
        cord_x_q <= zero_q ? 32'sd0 : $signed({2'b01, s_q[31:2]});
        cord_y_q <= zero_q ? 32'sd0 : $signed({2'b11, s_q[31:2]});
        exp_q    <= zero_q ? 6'sd0  : exp_of(k_q);
        err_q    <= zero_q;
      end
    end
  end

  // Alignment delay line, fed from the registered strobe so the tail entry
  // fires exactly CORDIC_LAT cycles after cord_vld; idle slots carry zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CORDIC_LAT; i++) begin
        dl_vld_q[i] <= 1'b0;
        dl_exp_q[i] <= '0;
        dl_err_q[i] <= 1'b0;
      end
    end else begin
      dl_vld_q[0] <= cord_vld_q;
      dl_exp_q[0] <= cord_vld_q ? exp_q : 6'sd0;
      dl_err_q[0] <= cord_vld_q & err_q;
      for (int i = 1; i < CORDIC_LAT; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_exp_q[i] <= dl_exp_q[i-1];
        dl_err_q[i] <= dl_err_q[i-1];
      end
    end
  end

  assign bus.cord_x   = cord_x_q;
  assign bus.cord_y   = cord_y_q;
  assign bus.cord_vld = cord_vld_q;
  assign bus.al_vld   = dl_vld_q[CORDIC_LAT-1];
  assign bus.al_exp   = dl_exp_q[CORDIC_LAT-1];
  assign bus.al_err   = dl_err_q[CORDIC_LAT-1];

endmodule

// File: tb/tb_log_range_reduce.sv
module tb_log_range_reduce;

  localparam int LAT = 19;

  logic clk;
  logic rst_n;
  log_range_reduce_if bus ();

  log_range_reduce #(.CORDIC_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        [31:0] x;
    logic        [31:0] y;
    logic signed [5:0]  e;
    logic               err;
    int                 cyc;
  } exp_t;

  exp_t cq[$];
  exp_t aq[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int al_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Independent reference: count leading zeros, normalise, build x/y/e.
  function automatic exp_t model(input logic [31:0] a, input int acc_edge);
    exp_t r;
    int clz;
    logic [31:0] nrm;
    int s_cyc;
    clz = 32;
    for (int i = 31; i >= 0; i--) begin
      if (a[i]) begin
        clz = 31 - i;
        break;
      end
    end
    if (a == 32'd0) begin
      r.x = 32'd0; r.y = 32'd0; r.e = 6'sd0; r.err = 1'b1; s_cyc = 0;
    end else begin
      nrm   = a << clz;
      r.x   = {2'b01, nrm[31:2]};
      r.y   = {2'b11, nrm[31:2]};
      r.e   = 6'(16 - clz);
      r.err = 1'b0;
      s_cyc = clz / 8 + clz % 8;
    end
    r.cyc = acc_edge + s_cyc + 1;
    return r;
  endfunction

  // Scoreboard monitor: cord_vld pops the CORDIC-side queue, al_vld the
  // aligned-output queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.cord_vld) begin
        checks++;
        if (cq.size() == 0) begin
          errors++;
          $display("FAIL cord_unexpected: cord_vld high at cycle %0d with nothing outstanding", cyc);
        end else begin
          exp_t t;
          exp_t u;
          t = cq.pop_front();
          if (bus.cord_x !== t.x || bus.cord_y !== t.y || cyc != t.cyc) begin
            errors++;
            $display("FAIL cord_out: got x=%h y=%h cyc=%0d, expected x=%h y=%h cyc=%0d",
                     bus.cord_x, bus.cord_y, cyc, t.x, t.y, t.cyc);
          end
          u     = t;
          u.cyc = t.cyc + LAT;
          aq.push_back(u);
        end
      end
      if (bus.al_vld) begin
        al_cnt++;
        checks++;
        if (aq.size() == 0) begin
          errors++;
          $display("FAIL al_unexpected: al_vld high at cycle %0d with nothing outstanding", cyc);
        end else begin
          exp_t t;
          t = aq.pop_front();
          if (bus.al_exp !== t.e || bus.al_err !== t.err || cyc != t.cyc) begin
            errors++;
            $display("FAIL al_out: got exp=%0d err=%b cyc=%0d, expected exp=%0d err=%b cyc=%0d",
                     bus.al_exp, bus.al_err, cyc, t.e, t.err, t.cyc);
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input bit hold, output int acc);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%b, expected 1 within 200 cycles", bus.in_ready);
      acc = -1;
      bus.in_valid = 1'b0;
    end else begin
      acc = cyc + 1;
      cq.push_back(model(a, acc));
      @(posedge clk);
      #1;
      if (!hold) bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((cq.size() != 0 || aq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cq.size() != 0 || aq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: outstanding cord=%0d al=%0d, expected 0 and 0", name, cq.size(), aq.size());
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (bus.cord_x !== 32'd0 || bus.cord_y !== 32'd0 || bus.cord_vld !== 1'b0 ||
        bus.al_vld !== 1'b0 || bus.al_exp !== 6'sd0 || bus.al_err !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: got x=%h y=%h cv=%b av=%b ae=%0d aerr=%b rdy=%b, expected all 0 and rdy=1",
               name, bus.cord_x, bus.cord_y, bus.cord_vld, bus.al_vld, bus.al_exp, bus.al_err, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_a     = 32'd0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_release");
  endtask

  task automatic test_single(input logic [31:0] a, input string name);
    int acc;
    send(a, 1'b0, acc);
    wait_drain(name);
  endtask

  task automatic test_singles();
    test_single(32'h0001_0000, "one");
    test_single(32'hFFFF_FFFF, "max");
    test_single(32'h0000_0001, "min");
    test_single(32'h0000_0000, "zero");
    test_single(32'h8000_0000, "top_bit");
    test_single(32'h0000_0100, "k23");
    for (int i = 0; i < 6; i++) test_single($urandom, "random");
  endtask

  task automatic test_back_to_back();
    int a1;
    int a2;
    int a3;
    send(32'h0001_0000, 1'b1, a1);
    send(32'h0080_0000, 1'b1, a2);
    send(32'h0000_0000, 1'b0, a3);
    checks++;
    if (a2 - a1 != 10) begin
      errors++;
      $display("FAIL b2b_accept1: second accepted %0d edges after first, expected 10", a2 - a1);
    end
    checks++;
    if (a3 - a2 != 3) begin
      errors++;
      $display("FAIL b2b_accept2: third accepted %0d edges after second, expected 3", a3 - a2);
    end
    wait_drain("b2b");
  endtask

  task automatic test_reset_mid();
    int acc;
    int n;
    int seen;
    send(32'h0001_0000, 1'b0, acc);
    n = 0;
    while (cq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    send(32'h0000_0001, 1'b0, acc);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_async");
    cq.delete();
    aq.delete();
    seen = al_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (al_cnt != seen) begin
      errors++;
      $display("FAIL reset_mid_al: %0d al_vld pulses after reset, expected 0", al_cnt - seen);
    end
    check_idle_outputs("reset_mid_after");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_singles();
    test_back_to_back();
    test_reset_mid();
    test_single(32'h0001_0000, "post_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/log_range_reduce.md
# log_range_reduce

Front-end for the hyperbolic-CORDIC natural-log datapath. It accepts an unsigned Q16.16 operand `a` over a valid/ready handshake and normalises it iteratively to `a = m·2^e`, with `m` in [0.5, 1). It then drives the CORDIC vectoring pipeline with `x = m+1` and `y = m−1` in signed Q2.30, so that `z = 2·atanh(y/x) = ln(m)`. The exponent `e` and an error flag travel through a delay line matched to the CORDIC latency, so the downstream adder can form `ln(a) = z + e·ln2` on aligned data.

## Interface
Parameters:
- `CORDIC_LAT`, default 19: cycles from `cord_vld` (x/y presented) to the CORDIC result being valid.

Ports:
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `in_valid` input 1: operand valid.
- `in_ready` output 1: block can accept an operand. Combinational; equals (state==IDLE).
- `in_a` input 32: unsigned Q16.16 operand.
- `cord_x` output 32: signed Q2.30 `m+1`, registered, fed to CORDIC `x`.
- `cord_y` output 32: signed Q2.30 `m−1`, registered, fed to CORDIC `y`.
- `cord_vld` output 1: one-cycle strobe marking the cycle in which `cord_x`/`cord_y` carry a new operand.
- `al_vld` output 1: strobe `CORDIC_LAT` cycles after `cord_vld`, aligned with the CORDIC `z` output.
- `al_exp` output 6: signed exponent `e`, aligned with `al_vld`.
- `al_err` output 1: operand was zero (ln undefined), aligned with `al_vld`.

## Operation
- FSM states: IDLE, NORM, EMIT.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: capture `s` ← `in_a` and `k` ← 0.
  - If `in_a`==0, go to EMIT with `err`=1; otherwise go to NORM.
- **NORM** (exactly one action per clock):
  - If `s[31:24]`==0: `s` ← `s`<<8, `k` += 8.
  - Else if `s[31]`==0: `s` ← `s`<<1, `k` += 1.
  - Else: go to EMIT (`s[31]`==1, normalised).
- **EMIT**
  - Register `cord_x` = {2'b01, `s[31:2]`} and `cord_y` = {2'b11, `s[31:2]`}.
  - Exponent `e` = 16 − `k`, range −15..+16.
  - Assert `cord_vld` for this one cycle, then return to IDLE.
- **Zero operand:** EMIT drives `cord_x`=`cord_y`=0, `e`=0, `err`=1.
- `cord_x`/`cord_y` hold their last value outside EMIT. The CORDIC samples every clock; only `cord_vld` cycles are meaningful.
- **Delay line:** `CORDIC_LAT`-deep shift register of {`vld`, `exp`, `err`}, advancing every clock. It is loaded with {1, `e`, `err`} in the EMIT cycle and {0, 0, 0} otherwise.
- `in_valid` is ignored outside IDLE; the operand must be held until accepted.
- Arithmetic: all shifts are logical left and zero-filling; `k` is 5 bits plus overflow headroom (max 31).

## Timing
- **Reset** (async assert, sync release sampled at `clk`):
  - state=IDLE, `s`=0, `k`=0.
  - `cord_x`=`cord_y`=0, `cord_vld`=0.
  - `al_vld`=0, `al_exp`=0, `al_err`=0, and the delay line is cleared.
  - `in_ready`=1.
- **Reset mid-operation:** the in-flight operand and every delay-line entry are discarded. No `al_vld` is emitted for them.
- **Latency:** let S = floor(k/8) + (k mod 8) be the number of shift cycles.
  - `cord_vld` is high in cycle S+1 after the accepting edge (edge 0).
  - `al_vld` is high `CORDIC_LAT` cycles after `cord_vld`.
  - Zero operand: S=0, so `cord_vld` is high in cycle 1.
- **Throughput:** the next operand is accepted no earlier than edge S+2; initiation interval is ≥ S+2 cycles. Results leave in acceptance order.
- Latency ranges:

| Case | S | `cord_vld` cycle | `al_vld` cycle (`CORDIC_LAT`=19) |
|---|---|---|---|
| Best (`s[31]` set on entry) | 0 | 1 | 20 |
| Worst (k=31) | 10 | 11 | 30 |

## Test plan
- `in_a`=0x00010000 (1.0) → k=15, `cord_vld` at cycle 9, `cord_x`=0x60000000, `cord_y`=0xE0000000. `al_vld` 19 cycles later with `al_exp`=+1, `al_err`=0.
- `in_a`=0xFFFFFFFF → `cord_vld` at cycle 1, `cord_x`=0x7FFFFFFF, `cord_y`=0xFFFFFFFF, `al_exp`=+16.
- `in_a`=0x00000001 → k=31, `cord_vld` at cycle 11, `cord_x`=0x60000000, `cord_y`=0xE0000000, `al_exp`=−15.
- `in_a`=0 → `cord_vld` at cycle 1, `cord_x`=`cord_y`=0. `al_vld` 19 cycles later with `al_err`=1, `al_exp`=0.
- `in_valid` held high with 0x00010000 then 0x00800000 → `in_ready` low through NORM/EMIT. The second operand is accepted at edge 10 of the first. Two `al_vld` pulses in order with `al_exp` = +1, then +8.
- `rst_n` pulsed low during NORM of 0x00000001, while an earlier result is still in the delay line → all outputs 0 immediately. No `al_vld` appears after release; `in_ready`=1.
